// File: rtl/cpi_link_manager.sv
// ---------------------------------------------------------------------------
// cpi_link_manager
//   CPI link manager for the CXL memory fabric manager. Runs the global-layer
//   connect / disconnect / fatal handshake with the agent, buffers A2F
//   request packets in a credit-flow-controlled FIFO and forwards them on the
//   F2A request channel under ready/valid.
//
// Ports
//   fm_clk, fm_rst           clock (posedge) / asynchronous active-low reset
//   a2f_txcon_req            agent connect request (level)
//   a2f_rxcon_ack            connect acknowledge (level)
//   a2f_rxdiscon_nack        disconnect reject, one-cycle pulse
//   a2f_rx_empty             request FIFO empty (registered)
//   a2f_fatal / f2a_fatal    agent fatal in / sticky fatal state out
//   a2f_req_*                A2F request (valid, protocol id, header)
//   a2f_req_crd_rtn          one-credit return pulse
//   f2a_req_*                F2A request (valid, protocol id, header, ready)
//   link_state               FSM state (0 DISC,1 CONNECTING,2 CONNECTED,
//                            3 DISCONNECTING,4 FATAL)
//   err_overflow, err_proto  sticky error flags
// ---------------------------------------------------------------------------
module cpi_link_manager #(
    parameter int HDR_W   = 129,
    parameter int PID_W   = 4,
    parameter int DEPTH   = 8,
    parameter int ACK_DLY = 2,
    parameter int NACK_EN = 1
) (
    input  logic             fm_clk,
    input  logic             fm_rst,
    input  logic             a2f_txcon_req,
    output logic             a2f_rxcon_ack,
    output logic             a2f_rxdiscon_nack,
    output logic             a2f_rx_empty,
    input  logic             a2f_fatal,
    output logic             f2a_fatal,
    input  logic             a2f_req_is_valid,
    input  logic [PID_W-1:0] a2f_req_protocol_id,
    input  logic [HDR_W-1:0] a2f_req_header,
    output logic             a2f_req_crd_rtn,
    output logic             f2a_req_is_valid,
    output logic [PID_W-1:0] f2a_req_protocol_id,
    output logic [HDR_W-1:0] f2a_req_header,
    input  logic             f2a_req_ready,
    output logic [2:0]       link_state,
    output logic             err_overflow,
    output logic             err_proto
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CW1   = CNT_W + 1;
    localparam int DLY_W = (ACK_DLY > 1) ? $clog2(ACK_DLY) : 1;
    localparam int ENT_W = PID_W + HDR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(ACK_DLY - 1);

    typedef enum logic [2:0] {
        S_DISC          = 3'd0,
        S_CONNECTING    = 3'd1,
        S_CONNECTED     = 3'd2,
        S_DISCONNECTING = 3'd3,
        S_FATAL         = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DLY_W-1:0] r_dly;
    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] w_occ_nxt;
    logic [CNT_W-1:0] r_crd_cnt;
    logic             r_nack;
    logic             r_crd_rtn;
    logic             r_empty;
    logic             r_err_ov;
    logic             r_err_proto;
    logic             w_link_up;
    logic             w_fifo_ne;
    logic             w_full;
    logic             w_pop;
    logic             w_push_try;
    logic             w_push;
    logic             w_flush;
    logic             w_crd_dec;
    logic             w_nack_nxt;
    logic             w_f2a_vld;

    // Pending credits can never legitimately exceed the FIFO depth; clamp
    // so a misbehaving agent cannot make us over-advertise.
    function automatic logic [CNT_W-1:0] sat_crd(input logic [CW1-1:0] v);
        if (v > CW1'(DEPTH))
            return FULL_CNT;
        else
            return v[CNT_W-1:0];
    endfunction

    // FSM state register
    always_ff @(posedge fm_clk or negedge fm_rst) begin
        if (!fm_rst)
            r_state <= S_DISC;
        else
            r_state <= w_state_nxt;
    end

    // FSM next-state logic; fatal overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (a2f_fatal) begin
            w_state_nxt = S_FATAL;
        end else begin
            case (r_state)
                S_DISC:
                    if (a2f_txcon_req) w_state_nxt = S_CONNECTING;
                S_CONNECTING:
                    if (!a2f_txcon_req)        w_state_nxt = S_DISC;
                    else if (r_dly == DLY_LAST) w_state_nxt = S_CONNECTED;
                S_CONNECTED:
                    if (!a2f_txcon_req) w_state_nxt = S_DISCONNECTING;
                S_DISCONNECTING:
                    if (!w_fifo_ne)        w_state_nxt = S_DISC;
                    else if (NACK_EN != 0) w_state_nxt = S_CONNECTED;
                S_FATAL:
                    w_state_nxt = S_FATAL;
                default:
                    w_state_nxt = S_DISC;
            endcase
        end
    end

    // FSM outputs and derived datapath controls
    always_comb begin
        w_link_up   = (r_state == S_CONNECTED) || (r_state == S_DISCONNECTING);
        w_fifo_ne   = (r_occ != '0);
        w_full      = (r_occ == FULL_CNT);
        w_f2a_vld   = w_link_up && w_fifo_ne;
        w_pop       = w_f2a_vld && f2a_req_ready;
        w_push_try  = a2f_req_is_valid && w_link_up;
        w_push      = w_push_try && (!w_full || w_pop);
        w_flush     = (w_state_nxt == S_FATAL);
        w_nack_nxt  = (r_state == S_DISCONNECTING) && (w_state_nxt == S_CONNECTED);
        // Credits are only returned while the link stays up next cycle.
        w_crd_dec   = (r_crd_cnt != '0) &&
                      ((w_state_nxt == S_CONNECTED) || (w_state_nxt == S_DISCONNECTING));
        w_occ_nxt   = r_occ + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    assign a2f_rxcon_ack       = w_link_up;
    assign f2a_fatal           = (r_state == S_FATAL);
    assign link_state          = r_state;
    assign a2f_rxdiscon_nack   = r_nack;
    assign a2f_req_crd_rtn     = r_crd_rtn;
    assign a2f_rx_empty        = r_empty;
    assign err_overflow        = r_err_ov;
    assign err_proto           = r_err_proto;
    assign f2a_req_is_valid    = w_f2a_vld;
    // Payload is forced to zero when idle so stale RAM never leaks out.
    assign f2a_req_header      = w_f2a_vld ? r_mem[r_rd_ptr][HDR_W-1:0]     : '0;
    assign f2a_req_protocol_id = w_f2a_vld ? r_mem[r_rd_ptr][ENT_W-1:HDR_W] : '0;

    // Connect delay counter
    always_ff @(posedge fm_clk or negedge fm_rst) begin
        if (!fm_rst)
            r_dly <= '0;
        else if (r_state == S_CONNECTING)
            r_dly <= r_dly + DLY_W'(1);
        else
            r_dly <= '0;
    end

    // FIFO pointers / occupancy; fatal entry discards everything
    always_ff @(posedge fm_clk or negedge fm_rst) begin
        if (!fm_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_empty  <= 1'b1;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_occ   <= w_occ_nxt;
            r_empty <= (w_occ_nxt == '0);
        end
    end

    // FIFO storage (data only, no reset)
    always_ff @(posedge fm_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {a2f_req_protocol_id, a2f_req_header};
    end

    // Credit return: full load on link-up, one per pop, one pulse per cycle
    always_ff @(posedge fm_clk or negedge fm_rst) begin
        if (!fm_rst) begin
            r_crd_cnt <= '0;
            r_crd_rtn <= 1'b0;
        end else begin
            r_crd_rtn <= w_crd_dec;
            if ((r_state == S_CONNECTING) && (w_state_nxt == S_CONNECTED))
                r_crd_cnt <= FULL_CNT;
            else if ((w_state_nxt == S_DISC) || (w_state_nxt == S_FATAL))
                r_crd_cnt <= '0;
            else
                r_crd_cnt <= sat_crd({1'b0, r_crd_cnt} - CW1'(w_crd_dec) + CW1'(w_pop));
        end
    end

    // Disconnect NACK pulse and sticky error flags
    always_ff @(posedge fm_clk or negedge fm_rst) begin
        if (!fm_rst) begin
            r_nack      <= 1'b0;
            r_err_ov    <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            r_nack <= w_nack_nxt;
            if (w_push_try && w_full && !w_pop)
                r_err_ov <= 1'b1;
            if (a2f_req_is_valid && !w_link_up)
                r_err_proto <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpi_link_manager.sv
module tb_cpi_link_manager;

    localparam int HDR_W   = 129;
    localparam int PID_W   = 4;
    localparam int DEPTH   = 8;
    localparam int ACK_DLY = 2;
    localparam int NACK_EN = 1;

    typedef logic [PID_W+HDR_W-1:0] ent_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             txcon_req = 1'b0;
    logic             rxcon_ack;
    logic             discon_nack;
    logic             rx_empty;
    logic             fatal_in = 1'b0;
    logic             fatal_out;
    logic             req_vld = 1'b0;
    logic [PID_W-1:0] req_pid = '0;
    logic [HDR_W-1:0] req_hdr = '0;
    logic             crd_rtn;
    logic             out_vld;
    logic [PID_W-1:0] out_pid;
    logic [HDR_W-1:0] out_hdr;
    logic             out_rdy = 1'b0;
    logic [2:0]       lstate;
    logic             e_ov;
    logic             e_proto;

    int checks = 0;
    int failures = 0;

    cpi_link_manager #(
        .HDR_W(HDR_W), .PID_W(PID_W), .DEPTH(DEPTH), .ACK_DLY(ACK_DLY), .NACK_EN(NACK_EN)
    ) dut (
        .fm_clk              (clk),
        .fm_rst              (rst_n),
        .a2f_txcon_req       (txcon_req),
        .a2f_rxcon_ack       (rxcon_ack),
        .a2f_rxdiscon_nack   (discon_nack),
        .a2f_rx_empty        (rx_empty),
        .a2f_fatal           (fatal_in),
        .f2a_fatal           (fatal_out),
        .a2f_req_is_valid    (req_vld),
        .a2f_req_protocol_id (req_pid),
        .a2f_req_header      (req_hdr),
        .a2f_req_crd_rtn     (crd_rtn),
        .f2a_req_is_valid    (out_vld),
        .f2a_req_protocol_id (out_pid),
        .f2a_req_header      (out_hdr),
        .f2a_req_ready       (out_rdy),
        .link_state          (lstate),
        .err_overflow        (e_ov),
        .err_proto           (e_proto)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [HDR_W-1:0] mkhdr(input int i);
        logic [63:0] a;
        logic [63:0] b;
        a = 64'hDEAD_BEEF_0000_0000 | 64'(i);
        b = 64'(i) * 64'd3 + 64'd7;
        return {1'(i & 1), a, b};
    endfunction

    // ---------------- behavioural model ----------------
    ent_t mq[$];
    int   m_state = 0;
    int   m_dly   = 0;
    int   m_cred  = 0;
    bit   m_ack = 0, m_nack = 0, m_crd = 0, m_fatal = 0, m_eov = 0, m_eproto = 0;

    task automatic model_step();
        bit up, popv, nack_n, crd_n;
        int nxt;
        if (!rst_n) begin
            mq.delete();
            m_state = 0; m_dly = 0; m_cred = 0;
            m_ack = 0; m_nack = 0; m_crd = 0; m_fatal = 0; m_eov = 0; m_eproto = 0;
            return;
        end
        up     = (m_state == 2) || (m_state == 3);
        popv   = up && (mq.size() > 0) && out_rdy;
        nxt    = m_state;
        nack_n = 0;
        if (fatal_in) nxt = 4;
        else begin
            case (m_state)
                0: if (txcon_req) begin nxt = 1; m_dly = 0; end
                1: if (!txcon_req) nxt = 0;
                   else begin
                       m_dly++;
                       if (m_dly >= ACK_DLY) begin nxt = 2; m_ack = 1; end
                   end
                2: if (!txcon_req) nxt = 3;
                3: if (mq.size() == 0) begin nxt = 0; m_ack = 0; end
                   else if (NACK_EN != 0) begin nxt = 2; nack_n = 1; end
                default: nxt = 4;
            endcase
        end
        if (req_vld && !up) m_eproto = 1;
        if (req_vld && up && mq.size() == DEPTH && !popv) m_eov = 1;
        if (popv) void'(mq.pop_front());
        if (req_vld && up && mq.size() < DEPTH) mq.push_back({req_pid, req_hdr});
        crd_n = (m_cred > 0) && (nxt == 2 || nxt == 3);
        if (m_state == 1 && nxt == 2) m_cred = DEPTH;
        else if (nxt == 0 || nxt == 4) m_cred = 0;
        else begin
            m_cred = m_cred - int'(crd_n) + int'(popv);
            if (m_cred > DEPTH) m_cred = DEPTH;
        end
        m_crd  = crd_n;
        m_nack = nack_n;
        if (nxt == 4) begin mq.delete(); m_ack = 0; m_fatal = 1; end
        m_state = nxt;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Per-cycle comparison against the model
    initial forever begin
        bit ev;
        @(posedge clk);
        #1;
        ev = ((m_state == 2) || (m_state == 3)) && (mq.size() > 0);
        chk("cmp_state",    160'(lstate),      160'(m_state));
        chk("cmp_ack",      160'(rxcon_ack),   160'(m_ack));
        chk("cmp_nack",     160'(discon_nack), 160'(m_nack));
        chk("cmp_empty",    160'(rx_empty),    160'(mq.size() == 0));
        chk("cmp_fatal",    160'(fatal_out),   160'(m_fatal));
        chk("cmp_crd",      160'(crd_rtn),     160'(m_crd));
        chk("cmp_vld",      160'(out_vld),     160'(ev));
        chk("cmp_eov",      160'(e_ov),        160'(m_eov));
        chk("cmp_eproto",   160'(e_proto),     160'(m_eproto));
        if (ev) begin
            chk("cmp_hdr", 160'(out_hdr), 160'(mq[0][HDR_W-1:0]));
            chk("cmp_pid", 160'(out_pid), 160'(mq[0][PID_W+HDR_W-1:HDR_W]));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic push_n(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            req_vld = 1'b1;
            req_pid = 4'(base + i);
            req_hdr = mkhdr(base + i);
            @(negedge clk);
        end
        req_vld = 1'b0;
    endtask

    task automatic wait_ack(input string nm);
        bit seen;
        seen = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (rxcon_ack) seen = 1;
        end
        chk(nm, 160'(seen), 160'(1));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int pulses;
        bit seen;
        repeat (3) @(negedge clk);
        chk("rst_ack",   160'(rxcon_ack), 160'(0));
        chk("rst_empty", 160'(rx_empty),  160'(1));
        chk("rst_state", 160'(lstate),    160'(0));
        chk("rst_vld",   160'(out_vld),   160'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 1: connect, ack at c3, credit pulses c4..c11
        txcon_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t1_ack_c2", 160'(rxcon_ack), 160'(0));
        @(posedge clk); #1;
        chk("t1_ack_c3",   160'(rxcon_ack), 160'(1));
        chk("t1_state_c3", 160'(lstate),    160'(2));
        pulses = 0;
        for (int c = 4; c <= 13; c++) begin
            @(posedge clk); #1;
            if (crd_rtn) pulses++;
            if (c == 4)  chk("t1_crd_c4",  160'(crd_rtn), 160'(1));
            if (c == 12) chk("t1_crd_c12", 160'(crd_rtn), 160'(0));
        end
        chk("t1_crd_pulses", 160'(pulses), 160'(8));

        // 2: fill with ready low, then in-order drain
        @(negedge clk);
        push_n(0, 8);
        @(negedge clk);
        chk("t2_empty", 160'(rx_empty), 160'(0));
        chk("t2_vld",   160'(out_vld),  160'(1));
        out_rdy = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                chk($sformatf("t2_pop%0d_hdr", i), 160'(out_hdr), 160'(mkhdr(i)));
                chk($sformatf("t2_pop%0d_pid", i), 160'(out_pid), 160'(4'(i)));
            end
            if (crd_rtn) pulses++;
            @(negedge clk);
        end
        chk("t2_crd_pulses", 160'(pulses), 160'(8));
        chk("t2_drained",    160'(rx_empty), 160'(1));
        out_rdy = 1'b0;

        // 3: overflow drop, then full push+pop accepted
        push_n(10, 8);
        chk("t3_no_ov_yet", 160'(e_ov), 160'(0));
        push_n(18, 1);
        chk("t3_ov", 160'(e_ov), 160'(1));
        req_vld = 1'b1; req_pid = 4'(19); req_hdr = mkhdr(19); out_rdy = 1'b1;
        @(negedge clk);
        req_vld = 1'b0; out_rdy = 1'b0;
        chk("t3_full_empty", 160'(rx_empty), 160'(0));
        chk("t3_head", 160'(out_hdr), 160'(mkhdr(11)));
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t3_drain%0d", i), 160'(out_hdr), 160'(mkhdr(i < 7 ? 11 + i : 19)));
            @(negedge clk);
        end
        out_rdy = 1'b0;
        chk("t3_drained", 160'(rx_empty), 160'(1));

        // 4: disconnect with entries queued -> nack, then drain and drop
        push_n(20, 3);
        txcon_req = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (discon_nack) begin
                seen = 1;
                chk("t4_state_nack", 160'(lstate),    160'(2));
                chk("t4_ack_nack",   160'(rxcon_ack), 160'(1));
                txcon_req = 1'b1;
            end
        end
        chk("t4_nack_seen", 160'(seen), 160'(1));
        @(negedge clk);
        chk("t4_nack_1cyc", 160'(discon_nack), 160'(0));
        out_rdy = 1'b1;
        repeat (4) @(negedge clk);
        out_rdy = 1'b0;
        txcon_req = 1'b0;
        for (int k = 0; k < 10 && lstate != 3'd0; k++) @(negedge clk);
        chk("t4_state_disc", 160'(lstate),    160'(0));
        chk("t4_ack_low",    160'(rxcon_ack), 160'(0));

        // protocol error: request while disconnected
        push_n(25, 1);
        chk("t4_eproto", 160'(e_proto),  160'(1));
        chk("t4_dropped", 160'(rx_empty), 160'(1));

        // 5: fatal mid-stream
        txcon_req = 1'b1;
        wait_ack("t5_ack_seen");
        push_n(30, 4);
        out_rdy = 1'b1;
        @(negedge clk);
        fatal_in = 1'b1;
        @(negedge clk);
        fatal_in = 1'b0;
        chk("t5_fatal", 160'(fatal_out), 160'(1));
        chk("t5_state", 160'(lstate),    160'(4));
        chk("t5_vld",   160'(out_vld),   160'(0));
        chk("t5_empty", 160'(rx_empty),  160'(1));
        chk("t5_ack",   160'(rxcon_ack), 160'(0));
        chk("t5_crd",   160'(crd_rtn),   160'(0));
        @(negedge clk);
        chk("t5_sticky", 160'(fatal_out), 160'(1));
        out_rdy = 1'b0;

        // 6: asynchronous reset mid-stream
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack("t6_ack_seen");
        push_n(40, 3);
        chk("t6_pre_empty", 160'(rx_empty), 160'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ack",   160'(rxcon_ack), 160'(0));
        chk("t6_empty", 160'(rx_empty),  160'(1));
        chk("t6_state", 160'(lstate),    160'(0));
        chk("t6_vld",   160'(out_vld),   160'(0));
        chk("t6_hdr",   160'(out_hdr),   160'(0));
        chk("t6_crd",   160'(crd_rtn),   160'(0));
        chk("t6_fatal", 160'(fatal_out), 160'(0));
        chk("t6_errs",  160'({e_ov, e_proto, discon_nack}), 160'(0));
        @(negedge clk);
        txcon_req = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
